// File: rtl/text_mem_arbiter_pkg.sv
// Shared types and default widths for the text memory arbiter.
// The default widths match an 80x25 text screen with attribute+character words.
package text_mem_arbiter_pkg;

    localparam int DEF_ADDR_W = 11;
    localparam int DEF_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RDWAIT = 2'd2,
        DONE   = 2'd3
    } state_t;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_t;

endpackage

// File: rtl/text_mem_arbiter_rr_lock_arb.sv
// Two-port round-robin arbiter with burst lock and a burst limit.
// Here "owner" means the port granted most recently, which doubles as the round-robin pointer.
module rr_lock_arb
    import text_mem_arbiter_pkg::*;
#(
    parameter int MAX_BURST = 16
) (
    input  logic  sys_clk,
    input  logic  rst_n,
    input  logic  a_req,
    input  logic  b_req,
    input  logic  a_lock,
    input  logic  b_lock,
    input  logic  grant_stb,
    input  logic  done_stb,
    output port_t winner,
    output port_t owner
);

    localparam int CNT_W = $clog2(MAX_BURST) + 1;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

    port_t            last_gnt;
    logic             lock_q;
    logic [CNT_W-1:0] burst_cnt;
    logic             owner_lock;

    assign owner      = last_gnt;
    assign owner_lock = (last_gnt == PORT_B) ? b_lock : a_lock;

    always_comb begin
        winner = PORT_A;
        if (a_req && !b_req) begin
            winner = PORT_A;
        end else if (b_req && !a_req) begin
            winner = PORT_B;
        end else if (a_req && b_req) begin
            // A locked owner keeps the memory until it has used up its burst allowance.
            if (lock_q && (burst_cnt < MAX_CNT)) begin
                winner = last_gnt;
            end else begin
                winner = (last_gnt == PORT_A) ? PORT_B : PORT_A;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt  <= PORT_B;
            lock_q    <= 1'b0;
            burst_cnt <= '0;
        end else if (grant_stb) begin
            last_gnt <= winner;
            if ((winner == last_gnt) && lock_q) begin
                if (burst_cnt != MAX_CNT) begin
                    burst_cnt <= burst_cnt + 1'b1;
                end
            end else begin
                burst_cnt <= '0;
            end
        end else if (done_stb) begin
            lock_q <= owner_lock;
            if (!owner_lock) begin
                burst_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/text_mem_arbiter.sv
// Shares the video driver's text memory port between the editor (A) and a second engine (B).
// One access per grant: IDLE -> ACCESS -> [RDWAIT] -> DONE -> IDLE.
module text_mem_arbiter
    import text_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int RD_LAT    = 1,
    parameter int MAX_BURST = 16
) (
    input  logic              sys_clk,
    input  logic              rst_n,
    input  logic              a_req,
    input  logic              a_we,
    input  logic              a_lock,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic              b_lock,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              a_gnt,
    output logic              b_gnt,
    output logic              a_ack,
    output logic              b_ack,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    input  logic [DATA_W-1:0] ret_data,
    output logic              busy
);

    state_t            state, state_next;
    port_t             winner, owner;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic [1:0]        lat_cnt;
    logic              grant_stb;
    logic              done_stb;
    logic              rd_last;

    assign grant_stb = (state == IDLE) && (a_req || b_req);
    assign done_stb  = (state == DONE);
    assign rd_last   = (state == RDWAIT) && (lat_cnt == 2'(RD_LAT));

    rr_lock_arb #(
        .MAX_BURST(MAX_BURST)
    ) u_arb (
        .sys_clk  (sys_clk),
        .rst_n    (rst_n),
        .a_req    (a_req),
        .b_req    (b_req),
        .a_lock   (a_lock),
        .b_lock   (b_lock),
        .grant_stb(grant_stb),
        .done_stb (done_stb),
        .winner   (winner),
        .owner    (owner)
    );

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant_stb) state_next = ACCESS;
            ACCESS:  state_next = we_q ? DONE : RDWAIT;
            RDWAIT:  if (rd_last) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            lat_cnt <= 2'd0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state <= state_next;
            if (grant_stb) begin
                we_q    <= (winner == PORT_B) ? b_we    : a_we;
                addr_q  <= (winner == PORT_B) ? b_addr  : a_addr;
                wdata_q <= (winner == PORT_B) ? b_wdata : a_wdata;
            end
            // The ACCESS cycle is the first cycle of read latency.
            if (state == ACCESS) begin
                lat_cnt <= 2'd1;
            end else if ((state == RDWAIT) && !rd_last) begin
                lat_cnt <= lat_cnt + 2'd1;
            end
            if (rd_last) begin
                rdata_q <= ret_data;
            end
        end
    end

    assign busy     = (state != IDLE);
    assign a_gnt    = busy && (owner == PORT_A);
    assign b_gnt    = busy && (owner == PORT_B);
    assign a_ack    = done_stb && (owner == PORT_A);
    assign b_ack    = done_stb && (owner == PORT_B);
    assign mem_we   = (state == ACCESS) && we_q;
    assign mem_addr = addr_q;
    assign mem_data = wdata_q;
    assign rdata    = rdata_q;

endmodule

// File: tb/tb_text_mem_arbiter.sv
// Scoreboard bench for text_mem_arbiter: directed transactions, queued expectations, ack/write monitor.
module tb_text_mem_arbiter;

    localparam int ADDR_W    = 11;
    localparam int DATA_W    = 16;
    localparam int RD_LAT    = 2;
    localparam int MAX_BURST = 4;

    logic              sys_clk = 1'b0;
    logic              rst_n   = 1'b1;
    logic              a_req = 1'b0, a_we = 1'b0, a_lock = 1'b0;
    logic [ADDR_W-1:0] a_addr = '0;
    logic [DATA_W-1:0] a_wdata = '0;
    logic              b_req = 1'b0, b_we = 1'b0, b_lock = 1'b0;
    logic [ADDR_W-1:0] b_addr = '0;
    logic [DATA_W-1:0] b_wdata = '0;
    logic              a_gnt, b_gnt, a_ack, b_ack, mem_we, busy;
    logic [DATA_W-1:0] rdata, mem_data, ret_data;
    logic [ADDR_W-1:0] mem_addr;

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] rd0, rd1;

    typedef struct { bit port; bit rd; logic [DATA_W-1:0] data; } ack_exp_t;
    typedef struct { logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] data; } wr_exp_t;
    ack_exp_t ack_q[$];
    wr_exp_t  wr_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    always #5 sys_clk = ~sys_clk;

    text_mem_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .MAX_BURST(MAX_BURST)
    ) dut (
        .sys_clk(sys_clk), .rst_n(rst_n),
        .a_req(a_req), .a_we(a_we), .a_lock(a_lock), .a_addr(a_addr), .a_wdata(a_wdata),
        .b_req(b_req), .b_we(b_we), .b_lock(b_lock), .b_addr(b_addr), .b_wdata(b_wdata),
        .a_gnt(a_gnt), .b_gnt(b_gnt), .a_ack(a_ack), .b_ack(b_ack), .rdata(rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data), .ret_data(ret_data),
        .busy(busy)
    );

    // Video driver memory model: two-cycle read pipeline, word 0x123 preloaded during reset.
    always @(posedge sys_clk) begin
        if (!rst_n) mem[11'h123] <= 16'h0742;
        else if (mem_we) mem[mem_addr] <= mem_data;
        rd0 <= mem[mem_addr];
        rd1 <= rd0;
    end
    assign ret_data = rd1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic expect_txn(input bit port, input bit we, input logic [ADDR_W-1:0] addr,
                              input logic [DATA_W-1:0] data);
        ack_exp_t e;
        wr_exp_t  w;
        e.port = port;
        e.rd   = !we;
        e.data = data;
        ack_q.push_back(e);
        if (we) begin
            w.addr = addr;
            w.data = data;
            wr_q.push_back(w);
        end
    endtask

    task automatic drive(input bit port, input bit req, input bit we, input logic [ADDR_W-1:0] addr,
                         input logic [DATA_W-1:0] wd, input bit lock);
        if (port) begin
            b_req = req; b_we = we; b_addr = addr; b_wdata = wd; b_lock = lock;
        end else begin
            a_req = req; a_we = we; a_addr = addr; a_wdata = wd; a_lock = lock;
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_a_gnt"}, a_gnt, 0);
        chk({tag, "_b_gnt"}, b_gnt, 0);
        chk({tag, "_a_ack"}, a_ack, 0);
        chk({tag, "_b_ack"}, b_ack, 0);
        chk({tag, "_mem_we"}, mem_we, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_data"}, mem_data, 0);
        chk({tag, "_rdata"}, rdata, 0);
    endtask

    // Single transaction, latency measured from the cycle req is raised to the cycle ack is seen.
    task automatic single(input string name, input bit port, input bit we, input logic [ADDR_W-1:0] addr,
                          input logic [DATA_W-1:0] data, input int exp_lat);
        int lat;
        bit got;
        expect_txn(port, we, addr, data);
        @(posedge sys_clk); #1;
        drive(port, 1'b1, we, addr, we ? data : 16'h0000, 1'b0);
        lat = 0;
        got = 1'b0;
        while (!got && lat < 20) begin
            @(posedge sys_clk); #1;
            lat++;
            got = port ? b_ack : a_ack;
        end
        drive(port, 1'b0, 1'b0, '0, '0, 1'b0);
        chk({name, "_latency"}, got ? lat : 32'hFFFF, exp_lat);
    endtask

    // Back-to-back writes from one port, holding req across transactions.
    task automatic port_seq(input bit port, input int n, input logic [ADDR_W-1:0] addr0,
                            input logic [DATA_W-1:0] d0, input bit lock);
        int k;
        int cyc;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        k = 0; cyc = 0; a = addr0; d = d0;
        drive(port, 1'b1, 1'b1, a, d, lock);
        while (k < n && cyc < 400) begin
            @(posedge sys_clk); #1;
            cyc++;
            if (port ? b_ack : a_ack) begin
                k++; a++; d++;
                if (k < n) drive(port, 1'b1, 1'b1, a, d, lock);
                else drive(port, 1'b0, 1'b0, '0, '0, 1'b0);
            end
        end
        chk(port ? "b_seq_count" : "a_seq_count", k, n);
    endtask

    task automatic apply_reset();
        @(posedge sys_clk); #2;
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
        repeat (2) @(posedge sys_clk);
        #2 rst_n = 1'b1;
    endtask

    // Monitor: every ack and every memory write must match the head of its queue.
    always @(negedge sys_clk) begin
        if (rst_n) begin
            if (a_ack || b_ack) begin
                chk("ack_onehot", a_ack & b_ack, 0);
                if (ack_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_ack: a_ack=%0b b_ack=%0b, expected none", a_ack, b_ack);
                end else begin
                    ack_exp_t e;
                    e = ack_q.pop_front();
                    chk("ack_port", b_ack, e.port);
                    if (e.rd) chk("rdata", rdata, e.data);
                end
            end
            if (mem_we) begin
                if (wr_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_write: addr=%0h data=%0h, expected no write", mem_addr, mem_data);
                end else begin
                    wr_exp_t w;
                    w = wr_q.pop_front();
                    chk("wr_addr", mem_addr, w.addr);
                    chk("wr_data", mem_data, w.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        #2 rst_n = 1'b0;
        #1 check_idle("reset");
        repeat (3) @(posedge sys_clk);
        #2 rst_n = 1'b1;
        #1 check_idle("rel");
        @(posedge sys_clk); #1;
        check_idle("first_cycle");

        single("a_write", 1'b0, 1'b1, 11'h050, 16'h1F41, 2);
        single("b_read", 1'b1, 1'b0, 11'h123, 16'h0742, 4);
        single("a_write2", 1'b0, 1'b1, 11'h051, 16'h2222, 2);
        chk("rdata_kept_on_write", rdata, 16'h0742);
        single("a_readback", 1'b0, 1'b0, 11'h050, 16'h1F41, 4);

        // Both ports continuously, no lock: strict alternation starting with A.
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            expect_txn(1'b0, 1'b1, 11'h100 + 11'(i), 16'hA000 + 16'(i));
            expect_txn(1'b1, 1'b1, 11'h200 + 11'(i), 16'hB000 + 16'(i));
        end
        @(posedge sys_clk); #1;
        fork
            port_seq(1'b0, 3, 11'h100, 16'hA000, 1'b0);
            port_seq(1'b1, 3, 11'h200, 16'hB000, 1'b0);
        join

        // B locked: five B grants, then A once, then B again.
        apply_reset();
        for (int i = 0; i < 5; i++) expect_txn(1'b1, 1'b1, 11'h300 + 11'(i), 16'hC000 + 16'(i));
        expect_txn(1'b0, 1'b1, 11'h380, 16'hD000);
        expect_txn(1'b1, 1'b1, 11'h305, 16'hC005);
        expect_txn(1'b1, 1'b1, 11'h306, 16'hC006);
        @(posedge sys_clk); #1;
        fork
            port_seq(1'b1, 7, 11'h300, 16'hC000, 1'b1);
            begin
                int w;
                w = 0;
                while (!b_gnt && w < 50) begin
                    @(posedge sys_clk); #1;
                    w++;
                end
                chk("b_first_gnt", b_gnt, 1);
                port_seq(1'b0, 1, 11'h380, 16'hD000, 1'b0);
            end
        join

        // Reset in RDWAIT aborts the read with no ack.
        @(posedge sys_clk); #1;
        drive(1'b0, 1'b1, 1'b0, 11'h123, 16'h0000, 1'b0);
        @(posedge sys_clk); #1;
        chk("rdwait_a_gnt", a_gnt, 1);
        @(posedge sys_clk); #1;
        chk("rdwait_busy", busy, 1);
        rst_n = 1'b0;
        #1 check_idle("rst_rdwait");
        drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
        repeat (2) @(posedge sys_clk);
        #2 rst_n = 1'b1;
        @(posedge sys_clk); #1;
        check_idle("after_abort");
        single("a_read_after_abort", 1'b0, 1'b0, 11'h123, 16'h0742, 4);

        // req dropped during ACCESS still completes with exactly one ack.
        expect_txn(1'b0, 1'b1, 11'h060, 16'h5A5A);
        @(posedge sys_clk); #1;
        drive(1'b0, 1'b1, 1'b1, 11'h060, 16'h5A5A, 1'b0);
        @(posedge sys_clk); #1;
        chk("drop_a_gnt", a_gnt, 1);
        drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
        n = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge sys_clk); #1;
            if (a_ack) n++;
        end
        chk("drop_ack_count", n, 1);
        chk("drop_busy", busy, 0);

        repeat (4) @(posedge sys_clk);
        chk("ack_q_empty", ack_q.size(), 0);
        chk("wr_q_empty", wr_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
